// File: rtl/lsr_ctrl_pkg.sv
// Shared state encoding and width helper for the MSB-first serializer.
package lsr_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsr_shift_core.sv
// Parallel-load left-shift register; load wins over shift.
module lsr_shift_core #(
  parameter int   BITS = 4,
  parameter logic FILL = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load,
  input  logic            shift_en,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST)           q <= '0;
    else if (load)     q <= din;
    else if (shift_en) q <= {q[BITS-2:0], FILL};
  end

endmodule

// File: rtl/lsr_serializer_ctrl.sv
// Sequencer for an MSB-first serializer: handshake load, stallable shift,
// first/last framing, done pulse and a programmable idle gap.
module lsr_serializer_ctrl
  import lsr_ctrl_pkg::*;
#(
  parameter int   BITS = 4,
  parameter int   GAP  = 1,
  parameter logic FILL = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] data,
  input  logic            valid,
  output logic            ready,
  input  logic            stall,
  output logic            ser_out,
  output logic            ser_valid,
  output logic            first,
  output logic            last,
  output logic            busy,
  output logic            done
);

  localparam int BCW = clog2_min1(BITS);
  localparam int GCW = clog2_min1(GAP + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS - 1);
  // GAP_LAST is unused when GAP==0; clamp so the constant stays legal.
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]      state;
  logic [BCW-1:0]  bit_cnt;
  logic [GCW-1:0]  gap_cnt;
  logic [BITS-1:0] shift_q;
  logic            accept;
  logic            shift_en;

  assign accept    = (state == ST_IDLE) && valid;
  assign shift_en  = (state == ST_SHIFT) && !stall;
  assign ready     = (state == ST_IDLE);
  assign busy      = (state == ST_SHIFT) || (state == ST_GAP);
  assign ser_valid = shift_en;
  assign first     = shift_en && (bit_cnt == '0);
  assign last      = shift_en && (bit_cnt == BIT_LAST);
  assign ser_out   = shift_q[BITS-1];

  lsr_shift_core #(
    .BITS (BITS),
    .FILL (FILL)
  ) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift_en (shift_en),
    .din      (data),
    .q        (shift_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!stall) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              gap_cnt <= '0;
              done    <= 1'b1;
              state   <= (GAP == 0) ? ST_IDLE : ST_GAP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsr_serializer_ctrl.sv
// Directed bench: BITS=4/GAP=1 instance plus a BITS=8/GAP=0 instance,
// serial bits checked against a queue of expected {bit,first,last}.
module tb_lsr_serializer_ctrl;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst4, valid4, stall4;
  logic [3:0] data4;
  logic       ready4, ser_out4, ser_valid4, first4, last4, busy4, done4;
  logic       rst8, valid8, stall8;
  logic [7:0] data8;
  logic       ready8, ser_out8, ser_valid8, first8, last8, busy8, done8;

  int   nchecks = 0;
  int   nerr    = 0;
  exp_t q4[$];
  exp_t q8[$];

  always #5 CLK = ~CLK;

  lsr_serializer_ctrl #(.BITS(4), .GAP(1), .FILL(1'b0)) u4 (
    .CLK(CLK), .RST(rst4), .data(data4), .valid(valid4), .ready(ready4),
    .stall(stall4), .ser_out(ser_out4), .ser_valid(ser_valid4),
    .first(first4), .last(last4), .busy(busy4), .done(done4)
  );

  lsr_serializer_ctrl #(.BITS(8), .GAP(0), .FILL(1'b0)) u8 (
    .CLK(CLK), .RST(rst8), .data(data8), .valid(valid8), .ready(ready8),
    .stall(stall8), .ser_out(ser_out8), .ser_valid(ser_valid8),
    .first(first8), .last(last8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic [3:0] w, input int n);
    for (int i = 0; i < n; i++) q4.push_back({w[3-i], (i == 0), (i == 3)});
  endtask

  task automatic push8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) q8.push_back({w[7-i], (i == 0), (i == 7)});
  endtask

  // Mid-cycle sample: pop the scoreboard on every valid serial bit.
  task automatic sample();
    exp_t e;
    #2;
    if (ser_valid4 === 1'b1) begin
      nchecks++;
      assert (q4.size() > 0) else begin
        nerr++;
        $error("FAIL extra_bit4: observed ser_valid=1 expected no bit pending");
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("bit4 {ser_out,first,last}", {ser_out4, first4, last4}, e);
      end
    end
    if (ser_valid8 === 1'b1) begin
      nchecks++;
      assert (q8.size() > 0) else begin
        nerr++;
        $error("FAIL extra_bit8: observed ser_valid=1 expected no bit pending");
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("bit8 {ser_out,first,last}", {ser_out8, first8, last8}, e);
      end
    end
    chk("done_vs_ser_valid4", done4 & ser_valid4, 0);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    rst4 = 1'b1; valid4 = 1'b0; stall4 = 1'b0; data4 = '0;
    rst8 = 1'b1; valid8 = 1'b0; stall8 = 1'b0; data8 = '0;
    repeat (3) adv();
    rst4 = 1'b0; rst8 = 1'b0;

    // Reset state
    sample();
    chk("rst ready4", ready4, 1);
    chk("rst busy4", busy4, 0);
    chk("rst done4", done4, 0);
    chk("rst outs4", {ser_out4, ser_valid4, first4, last4}, 0);
    chk("rst ready8", ready8, 1);
    chk("rst outs8", {ser_out8, ser_valid8, first8, last8, busy8, done8}, 0);
    adv();

    // Basic frame 1011
    valid4 = 1'b1; data4 = 4'b1011; push4(4'b1011, 4);
    sample(); chk("t1 c0 ready", ready4, 1); adv();
    valid4 = 1'b0;
    sample(); chk("t1 c1 ready", ready4, 0); chk("t1 c1 busy", busy4, 1); adv();
    idle(3);
    sample(); chk("t1 c5 done", done4, 1); chk("t1 c5 ready", ready4, 0);
    chk("t1 c5 busy", busy4, 1); adv();
    sample(); chk("t1 c6 ready", ready4, 1); chk("t1 c6 done", done4, 0); adv();
    chk("t1 drained", q4.size(), 0);

    // Same word, stall in cycles 2-3
    valid4 = 1'b1; data4 = 4'b1011; push4(4'b1011, 4);
    sample(); adv();
    valid4 = 1'b0;
    sample(); adv();
    stall4 = 1'b1;
    sample(); chk("t2 c2 ser_valid", ser_valid4, 0); chk("t2 c2 hold", ser_out4, 0); adv();
    sample(); chk("t2 c3 ser_valid", ser_valid4, 0); chk("t2 c3 hold", ser_out4, 0); adv();
    stall4 = 1'b0;
    sample(); adv();
    sample(); adv();
    sample(); chk("t2 c6 last", last4, 1); adv();
    sample(); chk("t2 c7 done", done4, 1); adv();
    sample(); chk("t2 c8 ready", ready4, 1); adv();
    chk("t2 drained", q4.size(), 0);

    // valid held high: A then 5, each sent once, GAP+1 dead cycles between
    valid4 = 1'b1; data4 = 4'hA; push4(4'hA, 4);
    sample(); adv();
    data4 = 4'h5; push4(4'h5, 4);
    idle(4);
    sample(); chk("t3 c5 ser_valid", ser_valid4, 0); chk("t3 c5 done", done4, 1); adv();
    sample(); chk("t3 c6 ser_valid", ser_valid4, 0); chk("t3 c6 ready", ready4, 1); adv();
    valid4 = 1'b0;
    sample(); chk("t3 c7 first", first4, 1); adv();
    idle(3);
    sample(); chk("t3 c11 done", done4, 1); adv();
    idle(2);
    chk("t3 drained", q4.size(), 0);

    // Reset in cycle 2 of a frame drops the word
    valid4 = 1'b1; data4 = 4'b1011; push4(4'b1011, 2);
    sample(); adv();
    valid4 = 1'b0;
    sample(); adv();
    rst4 = 1'b1;
    sample(); adv();
    rst4 = 1'b0;
    sample(); chk("t4 c3 ready", ready4, 1); chk("t4 c3 ser_valid", ser_valid4, 0);
    chk("t4 c3 done", done4, 0); adv();
    sample(); chk("t4 c4 done", done4, 0); chk("t4 c4 busy", busy4, 0); adv();
    chk("t4 partial drained", q4.size(), 0);
    valid4 = 1'b1; data4 = 4'b0110; push4(4'b0110, 4);
    sample(); adv();
    valid4 = 1'b0;
    idle(4);
    sample(); chk("t4 new done", done4, 1); adv();
    sample(); chk("t4 new ready", ready4, 1); adv();
    chk("t4 drained", q4.size(), 0);

    // Simultaneous reset and valid in IDLE
    rst4 = 1'b1; valid4 = 1'b1; data4 = 4'hF;
    sample(); adv();
    rst4 = 1'b0; valid4 = 1'b0;
    sample(); chk("t5 ready", ready4, 1); chk("t5 busy", busy4, 0);
    chk("t5 ser_valid", ser_valid4, 0); adv();
    sample(); chk("t5 busy later", busy4, 0); adv();

    // GAP=0, BITS=8; valid during SHIFT ignored
    valid8 = 1'b1; data8 = 8'h81; push8(8'h81);
    sample(); adv();
    data8 = 8'hFF;
    idle(7);
    valid8 = 1'b0;
    sample(); chk("t6 c8 last", last8, 1); adv();
    sample(); chk("t6 c9 done", done8, 1); chk("t6 c9 ready", ready8, 1);
    chk("t6 c9 ser_valid", ser_valid8, 0); adv();
    sample(); chk("t6 c10 done", done8, 0); chk("t6 c10 busy", busy8, 0);
    chk("t6 c10 ready", ready8, 1); adv();
    chk("t6 drained", q8.size(), 0);
    chk("final q4 empty", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
